// File: rtl/cpu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : cpu_pkg                                            |
// | Description : Shared types and constants for the ALU execution   |
// |               controller: FSM states, instruction field bit      |
// |               positions, status bit indices, datapath width.     |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
package cpu_pkg;

  // Datapath / instruction width and register-file geometry
  localparam int DW   = 16;
  localparam int NREG = 8;
  localparam int AW   = 3;
  localparam int SW   = 5;

  // Controller states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  // Instruction field bit positions
  localparam int c_mode_bit = 15;
  localparam int c_op_hi    = 14;
  localparam int c_op_lo    = 12;
  localparam int c_rd_hi    = 11;
  localparam int c_rd_lo    = 9;
  localparam int c_rs1_hi   = 8;
  localparam int c_rs1_lo   = 6;
  localparam int c_rs2_hi   = 5;
  localparam int c_rs2_lo   = 3;
  localparam int c_rsv_hi   = 2;

  // Status bit indices: status = {lt, gt, eq, zb, za}
  localparam int c_st_za = 0;
  localparam int c_st_zb = 1;
  localparam int c_st_eq = 2;
  localparam int c_st_gt = 3;
  localparam int c_st_lt = 4;

endpackage
`default_nettype wire

// File: rtl/regfile8x16.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : regfile8x16                                        |
// | Description : 8-entry register file with R0 tied to zero, one    |
// |               write port, two operand read latches loaded on     |
// |               request from the controller and a combinational    |
// |               debug read port.                                   |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module regfile8x16 #(
  parameter int DW   = cpu_pkg::DW,
  parameter int NREG = cpu_pkg::NREG
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_we,
  input  logic [cpu_pkg::AW-1:0] i_waddr,
  input  logic [DW-1:0]          i_wdata,
  input  logic                   i_rlatch,
  input  logic [cpu_pkg::AW-1:0] i_raddr1,
  input  logic [cpu_pkg::AW-1:0] i_raddr2,
  output logic [DW-1:0]          o_q1,
  output logic [DW-1:0]          o_q2,
  input  logic [cpu_pkg::AW-1:0] i_dbg_addr,
  output logic [DW-1:0]          o_dbg_data
);
  import cpu_pkg::*;

  logic [DW-1:0] w_mem [NREG];

  for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      // R0 has no storage: reads are constant zero, writes go nowhere
      assign w_mem[gi] = '0;
    end else begin : g_store
      logic [DW-1:0] r_q;
      // Storage cell, written when the write port addresses this entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (i_we && (i_waddr == AW'(gi))) begin
          r_q <= i_wdata;
        end
      end
      assign w_mem[gi] = r_q;
    end
  end

  // Operand latches: capture both sources together, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_q1 <= '0;
      o_q2 <= '0;
    end else if (i_rlatch) begin
      o_q1 <= w_mem[i_raddr1];
      o_q2 <= w_mem[i_raddr2];
    end
  end

  assign o_dbg_data = w_mem[i_dbg_addr];

endmodule
`default_nettype wire

// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : alu_exec_ctrl                                      |
// | Description : Four-state (IDLE/READ/EXEC/WB) controller feeding  |
// |               an external combinational ALU from an 8-entry      |
// |               register file and writing the result back.         |
// | Revision    : 1.0  initial release                               |
// +------------------------------------------------------------------+
module alu_exec_ctrl #(
  parameter int DW   = cpu_pkg::DW,
  parameter int NREG = cpu_pkg::NREG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  input  logic [DW-1:0] instr,
  output logic          instr_ready,
  input  logic          wr_en,
  input  logic [2:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [2:0]    rd_addr,
  output logic [DW-1:0] rd_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_opcode,
  output logic          alu_mode,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_za,
  input  logic          alu_zb,
  input  logic          alu_eq,
  input  logic          alu_gt,
  input  logic          alu_lt,
  output logic [4:0]    status,
  output logic          done
);
  import cpu_pkg::*;

  state_t          r_state;
  logic            r_mode;
  logic [2:0]      r_op;
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_rs1;
  logic [AW-1:0]   r_rs2;
  logic [DW-1:0]   r_result;
  logic [SW-1:0]   r_flags;

  logic            w_we;
  logic [AW-1:0]   w_waddr;
  logic [DW-1:0]   w_wdata;
  logic            w_rlatch;
  logic            w_unused;

  // Reserved instruction bits carry no meaning
  assign w_unused = ^instr[c_rsv_hi:0];

  // Single write port: writeback in WB, otherwise preload (IDLE only)
  assign w_we     = (r_state == S_WB) || ((r_state == S_IDLE) && wr_en);
  assign w_waddr  = (r_state == S_WB) ? r_rd     : wr_addr;
  assign w_wdata  = (r_state == S_WB) ? r_result : wr_data;
  assign w_rlatch = (r_state == S_READ);

  regfile8x16 #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (w_we),
    .i_waddr    (w_waddr),
    .i_wdata    (w_wdata),
    .i_rlatch   (w_rlatch),
    .i_raddr1   (r_rs1),
    .i_raddr2   (r_rs2),
    .o_q1       (alu_a),
    .o_q2       (alu_b),
    .i_dbg_addr (rd_addr),
    .o_dbg_data (rd_data)
  );

  // Controller FSM with registered ready/done/ALU-control/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 1'b0;
      r_op        <= '0;
      r_rd        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_result    <= '0;
      r_flags     <= '0;
      alu_opcode  <= '0;
      alu_mode    <= 1'b0;
      status      <= '0;
      done        <= 1'b0;
      instr_ready <= 1'b1;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (instr_valid) begin
            r_mode      <= instr[c_mode_bit];
            r_op        <= instr[c_op_hi:c_op_lo];
            r_rd        <= instr[c_rd_hi:c_rd_lo];
            r_rs1       <= instr[c_rs1_hi:c_rs1_lo];
            r_rs2       <= instr[c_rs2_hi:c_rs2_lo];
            instr_ready <= 1'b0;
            r_state     <= S_READ;
          end
        end
        S_READ: begin
          alu_opcode <= r_op;
          alu_mode   <= r_mode;
          r_state    <= S_EXEC;
        end
        S_EXEC: begin
          r_result <= alu_out;
          r_flags  <= {alu_lt, alu_gt, alu_eq, alu_zb, alu_za};
          done     <= 1'b1;
          r_state  <= S_WB;
        end
        S_WB: begin
          status      <= r_flags;
          instr_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          instr_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
